user_proj_sipo: RTL and testbench

Serial-in parallel-out receiver: the receiving end of the user-area PISO serial link. Deserializes an MSB-first framed bit stream into WIDTH-bit words and presents each word through a valid/ready holding register. Instantiated in `user_project_wrapper` beside the PISO block. The serial side connects to `io_in` pads and the parallel side to logic-analyzer or Wishbone-facing logic.

---
 rtl/user_proj_sipo.sv | 138 +++++++++++++
 tb/tb_user_proj_sipo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_proj_sipo.sv
// Serial-in parallel-out receiver: deserializes MSB-first framed bits into WIDTH-bit words
// behind a valid/ready holding register. Define SIPO_PARITY_EN to add a trailing even-parity bit.
module user_proj_sipo #(
  parameter int WIDTH = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             ser_din_i,
  input  logic             ser_vld_i,
  input  logic             ser_sof_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] par_dout_o,
  output logic             par_vld_o,
  input  logic             par_rdy_i,
  output logic             busy_o,
  output logic             ovr_o,
  output logic             perr_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sr, sr_nxt, sr_sh, word;
  logic             done;
  logic             load, drop;

`ifdef SIPO_PARITY_EN
  logic perr_set;

  // Even parity: data bits XOR parity bit must be zero.
  function automatic logic parity_ok(input logic [WIDTH-1:0] data, input logic pbit);
    return ((^data) ^ pbit) == 1'b0;
  endfunction
`endif

  assign sr_sh = {sr[WIDTH-2:0], ser_din_i};

`ifdef SIPO_PARITY_EN
  assign word = sr;
`else
  assign word = sr_sh;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    done      = 1'b0;
`ifdef SIPO_PARITY_EN
    perr_set  = 1'b0;
`endif
    if (ser_vld_i) begin
      if (ser_sof_i) begin
        // SOF always starts a fresh frame, aborting any frame in progress.
        state_nxt = SHIFT;
        cnt_nxt   = CW'(1);
        sr_nxt    = {{(WIDTH-1){1'b0}}, ser_din_i};
      end else begin
        case (state)
          SHIFT: begin
            sr_nxt  = sr_sh;
            cnt_nxt = cnt + CW'(1);
            if (cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
              state_nxt = PAR;
`else
              state_nxt = IDLE;
              cnt_nxt   = '0;
              done      = 1'b1;
`endif
            end
          end
`ifdef SIPO_PARITY_EN
          PAR: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            if (parity_ok(sr, ser_din_i)) done = 1'b1;
            else                          perr_set = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sr     <= sr_nxt;
      busy_o <= (state_nxt != IDLE);
    end
  end

  // Holding register is free when empty or being drained in this same cycle.
  assign load = done && (!par_vld_o || par_rdy_i);
  assign drop = done && par_vld_o && !par_rdy_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      par_dout_o <= '0;
      par_vld_o  <= 1'b0;
      ovr_o      <= 1'b0;
    end else begin
      if (load) begin
        par_dout_o <= word;
        par_vld_o  <= 1'b1;
      end else if (par_rdy_i) begin
        par_vld_o  <= 1'b0;
      end
      ovr_o <= drop | (ovr_o & ~clr_i);
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) perr_o <= 1'b0;
    else           perr_o <= perr_set | (perr_o & ~clr_i);
  end
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_user_proj_sipo.sv
// Self-checking bench for user_proj_sipo: scoreboard of expected words, one task per scenario.
module tb_user_proj_sipo;
  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         wb_clk_i, wb_rst_i;
  logic         ser_din_i, ser_vld_i, ser_sof_i, clr_i, par_rdy_i;
  logic [W-1:0] par_dout_o;
  logic         par_vld_o, busy_o, ovr_o, perr_o;

  int           passed = 0;
  int           total  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  user_proj_sipo #(.WIDTH(W)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .ser_din_i (ser_din_i),
    .ser_vld_i (ser_vld_i),
    .ser_sof_i (ser_sof_i),
    .clr_i     (clr_i),
    .par_dout_o(par_dout_o),
    .par_vld_o (par_vld_o),
    .par_rdy_i (par_rdy_i),
    .busy_o    (busy_o),
    .ovr_o     (ovr_o),
    .perr_o    (perr_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic frame_bit(input logic [W-1:0] w, input int k, input bit bad);
    if (k < W) return w[W-1-k];
    return (^w) ^ bad;
  endfunction

  task automatic tick();
    @(posedge wb_clk_i); #1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input int gaps, input bit rdy_last,
                            input bit clr_last, input bit bad);
    for (int k = 0; k < NB; k++) begin
      ser_vld_i = 1'b1;
      ser_din_i = frame_bit(w, k, bad);
      ser_sof_i = (k == 0);
      if (k == NB-1) begin
        if (rdy_last) par_rdy_i = 1'b1;
        if (clr_last) clr_i = 1'b1;
      end
      tick();
      ser_vld_i = 1'b0;
      ser_sof_i = 1'b0;
      if (k == NB-1) begin
        if (rdy_last) par_rdy_i = 1'b0;
        if (clr_last) clr_i = 1'b0;
      end else if (gaps > 0) begin
        repeat ($urandom_range(gaps)) tick();
      end
    end
  endtask

  task automatic pulse(input bit rdy, input bit clr);
    par_rdy_i = rdy;
    clr_i     = clr;
    tick();
    par_rdy_i = 1'b0;
    clr_i     = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b0;
    ser_din_i = 1'b0; ser_vld_i = 1'b0; ser_sof_i = 1'b0; clr_i = 1'b0; par_rdy_i = 1'b0;
    repeat (2) tick();
    total++; if (par_dout_o !== '0) $display("FAIL reset_dout: got %h want 00", par_dout_o); else passed++;
    total++; if (par_vld_o !== 1'b0) $display("FAIL reset_vld: got %b want 0", par_vld_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else passed++;
    total++; if (ovr_o !== 1'b0) $display("FAIL reset_ovr: got %b want 0", ovr_o); else passed++;
    total++; if (perr_o !== 1'b0) $display("FAIL reset_perr: got %b want 0", perr_o); else passed++;
    wb_rst_i = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    total++; if (par_vld_o !== 1'b1) $display("FAIL basic_vld: got %b want 1", par_vld_o); else passed++;
    exp_w = exp_q.pop_front();
    total++; if (par_dout_o !== exp_w) $display("FAIL basic_dout: got %h want %h", par_dout_o, exp_w); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy_o); else passed++;
    tick();
    total++; if (par_vld_o !== 1'b1 || par_dout_o !== exp_w)
      $display("FAIL basic_hold: got vld=%b dout=%h want vld=1 dout=%h", par_vld_o, par_dout_o, exp_w); else passed++;
    pulse(1'b1, 1'b0);
    total++; if (par_vld_o !== 1'b0) $display("FAIL basic_handshake: got %b want 0", par_vld_o); else passed++;
  endtask

  task automatic test_gapped();
    exp_q.push_back(8'h3C);
    for (int k = 0; k < NB; k++) begin
      ser_vld_i = 1'b1;
      ser_din_i = frame_bit(8'h3C, k, 1'b0);
      ser_sof_i = (k == 0);
      tick();
      ser_vld_i = 1'b0;
      ser_sof_i = 1'b0;
      if (k < NB-1) begin
        total++; if (busy_o !== 1'b1) $display("FAIL gap_busy_bit%0d: got %b want 1", k, busy_o); else passed++;
        for (int g = 0; g < (k % 4); g++) begin
          tick();
          total++; if (busy_o !== 1'b1 || par_vld_o !== 1'b0)
            $display("FAIL gap_idle_bit%0d: got busy=%b vld=%b want busy=1 vld=0", k, busy_o, par_vld_o); else passed++;
        end
      end
    end
    total++; if (busy_o !== 1'b0) $display("FAIL gap_busy_end: got %b want 0", busy_o); else passed++;
    total++; if (par_vld_o !== 1'b1) $display("FAIL gap_vld: got %b want 1", par_vld_o); else passed++;
    exp_w = exp_q.pop_front();
    total++; if (par_dout_o !== exp_w) $display("FAIL gap_dout: got %h want %h", par_dout_o, exp_w); else passed++;
    pulse(1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1, 1'b0, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    total++; if (par_dout_o !== exp_w || par_vld_o !== 1'b1)
      $display("FAIL ovr_hold: got vld=%b dout=%h want vld=1 dout=%h", par_vld_o, par_dout_o, exp_w); else passed++;
    total++; if (ovr_o !== 1'b1) $display("FAIL ovr_set: got %b want 1", ovr_o); else passed++;
    pulse(1'b1, 1'b1);
    total++; if (par_vld_o !== 1'b0) $display("FAIL ovr_consume: got %b want 0", par_vld_o); else passed++;
    total++; if (ovr_o !== 1'b0) $display("FAIL ovr_clear: got %b want 0", ovr_o); else passed++;

    exp_q.push_back(8'h11);
    send_frame(8'h11, 0, 1'b0, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    total++; if (par_dout_o !== exp_w) $display("FAIL ovr_first: got %h want %h", par_dout_o, exp_w); else passed++;
    exp_q.push_back(8'h22);
    send_frame(8'h22, 0, 1'b1, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    total++; if (par_dout_o !== exp_w || par_vld_o !== 1'b1)
      $display("FAIL ovr_sameclk_load: got vld=%b dout=%h want vld=1 dout=%h", par_vld_o, par_dout_o, exp_w); else passed++;
    total++; if (ovr_o !== 1'b0) $display("FAIL ovr_sameclk_flag: got %b want 0", ovr_o); else passed++;

    send_frame(8'h66, 0, 1'b0, 1'b1, 1'b0);
    total++; if (ovr_o !== 1'b1) $display("FAIL ovr_set_beats_clr: got %b want 1", ovr_o); else passed++;
    total++; if (par_dout_o !== 8'h22) $display("FAIL ovr_keep_word: got %h want 22", par_dout_o); else passed++;
    pulse(1'b1, 1'b1);
    total++; if (par_vld_o !== 1'b0 || ovr_o !== 1'b0)
      $display("FAIL ovr_final: got vld=%b ovr=%b want 0 0", par_vld_o, ovr_o); else passed++;
  endtask

  task automatic test_resync();
    logic [4:0] partial;
    partial = 5'b10110;
    for (int k = 0; k < 5; k++) begin
      ser_vld_i = 1'b1;
      ser_din_i = partial[4-k];
      ser_sof_i = (k == 0);
      tick();
    end
    ser_vld_i = 1'b0; ser_sof_i = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 0, 1'b0, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    total++; if (par_dout_o !== exp_w || par_vld_o !== 1'b1)
      $display("FAIL resync_word: got vld=%b dout=%h want vld=1 dout=%h", par_vld_o, par_dout_o, exp_w); else passed++;
    total++; if (ovr_o !== 1'b0 || perr_o !== 1'b0)
      $display("FAIL resync_flags: got ovr=%b perr=%b want 0 0", ovr_o, perr_o); else passed++;
    pulse(1'b1, 1'b0);
    tick();
    total++; if (par_vld_o !== 1'b0) $display("FAIL resync_single: got %b want 0", par_vld_o); else passed++;
  endtask

  task automatic test_back_to_back();
    par_rdy_i = 1'b1;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    send_frame(8'h81, 0, 1'b0, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    total++; if (par_dout_o !== exp_w || par_vld_o !== 1'b1)
      $display("FAIL b2b_first: got vld=%b dout=%h want vld=1 dout=%h", par_vld_o, par_dout_o, exp_w); else passed++;
    send_frame(8'h7E, 0, 1'b0, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    total++; if (par_dout_o !== exp_w || par_vld_o !== 1'b1)
      $display("FAIL b2b_second: got vld=%b dout=%h want vld=1 dout=%h", par_vld_o, par_dout_o, exp_w); else passed++;
    tick();
    par_rdy_i = 1'b0;
    total++; if (par_vld_o !== 1'b0 || ovr_o !== 1'b0)
      $display("FAIL b2b_drain: got vld=%b ovr=%b want 0 0", par_vld_o, ovr_o); else passed++;
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    total++; if (par_dout_o !== exp_w || par_vld_o !== 1'b1)
      $display("FAIL par_good: got vld=%b dout=%h want vld=1 dout=%h", par_vld_o, par_dout_o, exp_w); else passed++;
    total++; if (perr_o !== 1'b0) $display("FAIL par_good_flag: got %b want 0", perr_o); else passed++;
    pulse(1'b1, 1'b0);
    send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b1);
    total++; if (par_vld_o !== 1'b0) $display("FAIL par_bad_vld: got %b want 0", par_vld_o); else passed++;
    total++; if (perr_o !== 1'b1) $display("FAIL par_bad_flag: got %b want 1", perr_o); else passed++;
    pulse(1'b0, 1'b1);
    total++; if (perr_o !== 1'b0) $display("FAIL par_clear: got %b want 0", perr_o); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    send_frame(8'h12, 0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h34, 0, 1'b0, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    send_frame(8'h56, 0, 1'b0, 1'b0, 1'b1);
`endif
    for (int k = 0; k < 4; k++) begin
      ser_vld_i = 1'b1;
      ser_din_i = 1'b1;
      ser_sof_i = (k == 0);
      tick();
    end
    ser_vld_i = 1'b0; ser_sof_i = 1'b0;
    total++; if (busy_o !== 1'b1 || ovr_o !== 1'b1)
      $display("FAIL rst_pre: got busy=%b ovr=%b want 1 1", busy_o, ovr_o); else passed++;
    #2 wb_rst_i = 1'b0;
    #1;
    total++; if (par_vld_o !== 1'b0 || par_dout_o !== '0)
      $display("FAIL rst_async_word: got vld=%b dout=%h want 0 00", par_vld_o, par_dout_o); else passed++;
    total++; if (busy_o !== 1'b0 || ovr_o !== 1'b0 || perr_o !== 1'b0)
      $display("FAIL rst_async_flags: got busy=%b ovr=%b perr=%b want 0 0 0", busy_o, ovr_o, perr_o); else passed++;
    exp_q.delete();
    tick();
    wb_rst_i = 1'b1;
    tick();
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 0, 1'b0, 1'b0, 1'b0);
    exp_w = exp_q.pop_front();
    total++; if (par_dout_o !== exp_w || par_vld_o !== 1'b1)
      $display("FAIL rst_after_word: got vld=%b dout=%h want vld=1 dout=%h", par_vld_o, par_dout_o, exp_w); else passed++;
    total++; if (ovr_o !== 1'b0 || perr_o !== 1'b0)
      $display("FAIL rst_after_flags: got ovr=%b perr=%b want 0 0", ovr_o, perr_o); else passed++;
    pulse(1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_resync();
    test_back_to_back();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
